// File: rtl/eru_recovery.sv
// Error-detection and recovery stage for the bcsa_eru approximate adders.
// Optional ERU_STATS_EN adds a saturating count of erroneous transactions.
module eru_recovery #(
    parameter int WIDTH = 32,
    parameter int BLK   = 2,
    parameter int CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic [WIDTH:0]                    approx_sum,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH:0]                    exact_sum,
    output logic                              err_flag,
    output logic [$clog2(WIDTH/BLK):0]        err_blocks,
    output logic [CNT_W-1:0]                  err_count
);

    localparam int NB  = WIDTH / BLK;
    localparam int EBW = $clog2(NB) + 1;

    typedef enum logic [1:0] {IDLE, CHECK, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH:0]   result_q, exact_q;
    logic [NB-1:0]    mask_q;

    logic [WIDTH:0]   exact_c, fixed_c;
    logic [NB-1:0]    mask_c, low_c, rest_c;
    logic [EBW-1:0]   pc_c;

    assign exact_c = {1'b0, a_q} + {1'b0, b_q};

    // The top block also owns the carry-out bit WIDTH.
    always_comb begin
        mask_c = '0;
        pc_c   = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            mask_c[k] = (exact_c[k*BLK +: BLK] != result_q[k*BLK +: BLK]);
        end
        mask_c[NB-1] = mask_c[NB-1] | (exact_c[WIDTH] != result_q[WIDTH]);
        for (int unsigned k = 0; k < NB; k++) begin
            pc_c = pc_c + EBW'(mask_c[k]);
        end
    end

    // Isolate the lowest pending block and splice its exact bits into the result.
    always_comb begin
        low_c   = mask_q & (~mask_q + NB'(1));
        rest_c  = mask_q & ~low_c;
        fixed_c = result_q;
        for (int unsigned k = 0; k < NB; k++) begin
            if (low_c[k]) fixed_c[k*BLK +: BLK] = exact_q[k*BLK +: BLK];
        end
        if (low_c[NB-1]) fixed_c[WIDTH] = exact_q[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            exact_sum  <= '0;
            err_flag   <= 1'b0;
            err_blocks <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            exact_q    <= '0;
            mask_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        result_q <= approx_sum;
                        in_ready <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    exact_q    <= exact_c;
                    mask_q     <= mask_c;
                    err_blocks <= pc_c;
                    err_flag   <= |mask_c;
                    if (mask_c == '0) begin
                        exact_sum <= result_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fixed_c;
                    mask_q   <= rest_c;
                    if (rest_c == '0) begin
                        exact_sum <= fixed_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ERU_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state == CHECK && mask_c != '0 && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_eru_recovery.sv
// Directed bench for eru_recovery: vector table plus backpressure, reset and stats sequences.
module tb_eru_recovery;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [32:0] approx_sum;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] exact_sum;
    logic        err_flag;
    logic [4:0]  err_blocks;
    logic [1:0]  err_count;

    int checks = 0;
    int errors = 0;

    eru_recovery #(.WIDTH(32), .BLK(2), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exact_sum  (exact_sum),
        .err_flag   (err_flag),
        .err_blocks (err_blocks),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] ap;
        logic [32:0] sum;
        logic        flag;
        int          blocks;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one bundle and return just after the accepting edge with junk on the inputs.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [32:0] tap);
        @(negedge clk);
        a = ta; b = tb_; approx_sum = tap; in_valid = 1'b1;
        chk("ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        a          = $urandom;
        b          = $urandom;
        approx_sum = {1'b1, 32'($urandom)};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid) chk("in_ready_busy", 64'(in_ready), 64'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        logic [32:0] hold_sum;
        logic [1:0]  exp_cnt;

        vt[0] = '{32'h0000_0005, 32'h0000_000A, 33'h0_0000_000F, 33'h0_0000_000F, 1'b0, 0};
        vt[1] = '{32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000, 33'h0_0000_0004, 1'b1, 1};
        vt[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_5555_5555, 33'h1_0000_0000, 1'b1, 16};
        vt[3] = '{32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, 33'h0_2345_6789, 1'b0, 0};
        vt[4] = '{32'h0000_00FF, 32'h0000_0001, 33'h0_0000_00F0, 33'h0_0000_0100, 1'b1, 3};
        vt[5] = '{32'h8000_0000, 32'h8000_0000, 33'h0_0000_0003, 33'h1_0000_0000, 1'b1, 2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; approx_sum = '0;
        do_reset();

        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_exact_sum",  64'(exact_sum),  64'd0);
        chk("rst_err_flag",   64'(err_flag),   64'd0);
        chk("rst_err_blocks", 64'(err_blocks), 64'd0);
        chk("rst_err_count",  64'(err_count),  64'd0);

        for (int i = 0; i < 6; i++) begin
            send(vt[i].a, vt[i].b, vt[i].ap);
            wait_valid(lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(1 + vt[i].blocks));
            chk($sformatf("v%0d_sum", i),     64'(exact_sum),  64'(vt[i].sum));
            chk($sformatf("v%0d_flag", i),    64'(err_flag),   64'(vt[i].flag));
            chk($sformatf("v%0d_blocks", i),  64'(err_blocks), 64'(vt[i].blocks));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_drop", i), 64'(out_valid), 64'd0);
            chk($sformatf("v%0d_ready_back", i), 64'(in_ready),  64'd1);
        end

        // Backpressure on the single-error case
        out_ready = 1'b0;
        send(32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd2);
        hold_sum = exact_sum;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid",    64'(out_valid),  64'd1);
            chk("bp_sum",      64'(exact_sum),  64'h0_0000_0004);
            chk("bp_sum_hold", 64'(exact_sum),  64'(hold_sum));
            chk("bp_flag",     64'(err_flag),   64'd1);
            chk("bp_blocks",   64'(err_blocks), 64'd1);
            chk("bp_in_ready", 64'(in_ready),   64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_ready_back", 64'(in_ready),  64'd1);

        // Reset in the middle of the worst-case repair
        send(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_5555_5555);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_in_ready",  64'(in_ready),  64'd1);
        chk("mr_exact_sum", 64'(exact_sum), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) chk("mr_no_stale_valid", 64'(out_valid), 64'd0);
        end
        chk("mr_idle_ready", 64'(in_ready), 64'd1);
        send(32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000);
        wait_valid(lat);
        chk("mr_clean_latency", 64'(lat), 64'd2);
        chk("mr_clean_sum",     64'(exact_sum), 64'h0_0000_0004);
        @(posedge clk);
        #1;

        // Saturating error counter over five erroneous transactions
        do_reset();
        chk("st_count_reset", 64'(err_count), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            send(32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000);
            wait_valid(lat);
`ifdef ERU_STATS_EN
            exp_cnt = (i > 3) ? 2'd3 : 2'(i);
`else
            exp_cnt = 2'd0;
`endif
            chk($sformatf("st_count_%0d", i), 64'(err_count), 64'(exp_cnt));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
